fadd40_norm_shift: RTL and testbench

FADD40_NORM_SHIFT -- requirements
Module: fadd40_norm_shift

---
 rtl/fadd40_norm_shift.sv | 128 ++++++++++++
 tb/tb_fadd40_norm_shift.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd40_norm_shift.sv
// fadd40_norm_shift -- normalization shifter for the FADD_40 datapath.
//
// Left-shifts a 41-bit unnormalized mantissa so its MSB lands on bit 40,
// using the leading-zero count from the LZD, and lowers the exponent to
// match. The shift is limited by the exponent: when the exponent cannot
// absorb the full count, the mantissa is shifted by the exponent and the
// result is flagged as a denormal (underflow) with exponent 0.
//
// Two-stage valid/ready pipeline:
//   stage 1: zero/underflow flags, adjusted exponent, coarse shift (x8)
//   stage 2: fine shift (0..7), drives the outputs
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     input handshake
//   i_mant, i_exp         mantissa and biased exponent
//   i_lzd_num             leading-zero count of i_mant (40 for zero and 1)
//   o_valid / i_ready     output handshake
//   o_mant, o_exp         normalized mantissa, adjusted exponent
//   o_zero, o_underflow   zero input, exponent-limited (denormal) result
module fadd40_norm_shift #(
  parameter int EXP_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [40:0]      i_mant,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [5:0]       i_lzd_num,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [40:0]      o_mant,
  output logic [EXP_W-1:0] o_exp,
  output logic             o_zero,
  output logic             o_underflow
);

  // Common width for comparing the 6-bit count against the exponent.
  localparam int CW = (EXP_W > 6) ? EXP_W : 6;

  logic             in_zero;
  logic [5:0]       lzd;
  logic [CW-1:0]    lzd_w;
  logic [CW-1:0]    exp_w;
  logic             norm_ok;
  logic [5:0]       shamt;
  logic [EXP_W-1:0] exp_adj;
  logic [40:0]      coarse;

  logic             s1_valid;
  logic [40:0]      s1_mant;
  logic [2:0]       s1_fine;
  logic [EXP_W-1:0] s1_exp;
  logic             s1_zero;
  logic             s1_uf;
  logic             s2_valid;

  logic             load1;
  logic             load2;

  // Stage-1 combinational: shift amount, exponent, coarse shift.
  always_comb begin
    // A count of 40 means either zero or only bit 0 set, so zero is
    // detected from the mantissa itself.
    in_zero = (i_mant == '0);
    lzd     = (i_lzd_num > 6'd40) ? 6'd40 : i_lzd_num;
    lzd_w   = CW'(lzd);
    exp_w   = CW'(i_exp);
    norm_ok = lzd_w < exp_w;
    shamt   = '0;
    exp_adj = '0;
    if (!in_zero) begin
      if (norm_ok) begin
        shamt   = lzd;
        exp_adj = EXP_W'(exp_w - lzd_w);
      end else begin
        // Here i_exp <= lzd <= 40, so it fits in 6 bits.
        shamt = 6'(exp_w);
      end
    end
    coarse = i_mant << {shamt[5:3], 3'b000};
  end

  // Stage 2 advances when empty or drained; stage 1 when empty or moving.
  assign load2   = !s2_valid || i_ready;
  assign load1   = !s1_valid || load2;
  assign o_ready = load1;
  assign o_valid = s2_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid    <= 1'b0;
      s1_mant     <= '0;
      s1_fine     <= '0;
      s1_exp      <= '0;
      s1_zero     <= 1'b0;
      s1_uf       <= 1'b0;
      s2_valid    <= 1'b0;
      o_mant      <= '0;
      o_exp       <= '0;
      o_zero      <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (load1) begin
        s1_valid <= i_valid;
        if (i_valid) begin
          s1_mant <= coarse;
          s1_fine <= shamt[2:0];
          s1_exp  <= exp_adj;
          s1_zero <= in_zero;
          s1_uf   <= !in_zero && !norm_ok;
        end
      end
      if (load2) begin
        s2_valid <= s1_valid;
        // Data only moves with a real beat so outputs stay put when idle.
        if (s1_valid) begin
          o_mant      <= s1_mant << s1_fine;
          o_exp       <= s1_exp;
          o_zero      <= s1_zero;
          o_underflow <= s1_uf;
        end
      end
    end
  end

endmodule

// File: tb/tb_fadd40_norm_shift.sv
module tb_fadd40_norm_shift;
  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, o_ready, o_valid, i_ready, o_zero, o_underflow;
  logic [40:0] i_mant, o_mant;
  logic [7:0]  i_exp, o_exp;
  logic [5:0]  i_lzd_num;

  fadd40_norm_shift #(.EXP_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mant(i_mant), .i_exp(i_exp), .i_lzd_num(i_lzd_num),
    .o_valid(o_valid), .i_ready(i_ready), .o_mant(o_mant), .o_exp(o_exp),
    .o_zero(o_zero), .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [40:0] mant;
    logic [7:0]  exp;
    logic        zero;
    logic        uf;
    int          cyc;
  } beat_t;

  beat_t sb[$];
  int total = 0, bad = 0, cyc = 0, pops = 0;
  bit chk_lat = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic beat_t model(logic [40:0] m, logic [7:0] e, logic [5:0] l);
    beat_t b;
    int lz;
    lz = (l > 40) ? 40 : int'(l);
    b.cyc = cyc;
    if (m == 0) begin
      b.mant = '0; b.exp = '0; b.zero = 1'b1; b.uf = 1'b0;
    end else if (lz < int'(e)) begin
      b.mant = m << lz; b.exp = e - 8'(lz); b.zero = 1'b0; b.uf = 1'b0;
    end else begin
      b.mant = m << e; b.exp = '0; b.zero = 1'b0; b.uf = 1'b1;
    end
    return b;
  endfunction

  function automatic logic [5:0] count_lz(logic [40:0] m);
    for (int b = 40; b >= 0; b--) if (m[b]) return 6'(40 - b);
    return 6'd40;
  endfunction

  // Scoreboard: push on accepted input, pop and compare on consumed output.
  always @(negedge i_clk) begin : mon
    beat_t e;
    if (!i_rst) begin
      if (o_valid && i_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected got mant=%h exp=%0d", o_mant, o_exp);
        end else begin
          e = sb.pop_front();
          pops++;
          if ({o_mant, o_exp, o_zero, o_underflow} !== {e.mant, e.exp, e.zero, e.uf}) begin
            bad++;
            $display("FAIL sb_data got mant=%h exp=%0d z=%b uf=%b exp mant=%h exp=%0d z=%b uf=%b",
                     o_mant, o_exp, o_zero, o_underflow, e.mant, e.exp, e.zero, e.uf);
          end
          if (chk_lat) begin
            total++;
            if (cyc - e.cyc !== 2) begin
              bad++;
              $display("FAIL latency got %0d exp 2", cyc - e.cyc);
            end
          end
        end
      end
      if (i_valid && o_ready) sb.push_back(model(i_mant, i_exp, i_lzd_num));
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic send(input logic [40:0] m, input logic [7:0] e, input logic [5:0] l);
    bit acc;
    acc = 1'b0;
    i_valid = 1'b1; i_mant = m; i_exp = e; i_lzd_num = l;
    for (int n = 0; n < 50; n++) begin
      acc = o_ready;
      tick();
      if (acc) break;
    end
    i_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout got o_ready=0 exp 1");
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got pending=%0d exp 0", sb.size());
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b0;
    i_mant = 41'h1; i_exp = 8'd9; i_lzd_num = 6'd40;
    repeat (3) tick();
    total += 5;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b exp 0", o_valid); end
    if (o_mant !== 41'h0) begin bad++; $display("FAIL rst_mant got %h exp 0", o_mant); end
    if (o_exp !== 8'h0) begin bad++; $display("FAIL rst_exp got %0d exp 0", o_exp); end
    if (o_zero !== 1'b0) begin bad++; $display("FAIL rst_zero got %b exp 0", o_zero); end
    if (o_underflow !== 1'b0) begin bad++; $display("FAIL rst_uf got %b exp 0", o_underflow); end
    i_valid = 1'b0;
    i_rst = 1'b0;
    tick();
    total += 2;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b exp 1", o_ready); end
    if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid_after got %b exp 0", o_valid); end
  endtask

  task automatic test_normal();
    i_ready = 1'b1; chk_lat = 1'b1;
    send(41'h000_0000_0100, 8'd100, 6'd32);
    tick();
    total += 5;
    if (o_valid !== 1'b1) begin bad++; $display("FAIL norm_valid got %b exp 1", o_valid); end
    if (o_mant !== 41'h100_0000_0000) begin bad++; $display("FAIL norm_mant got %h exp 10000000000", o_mant); end
    if (o_exp !== 8'd68) begin bad++; $display("FAIL norm_exp got %0d exp 68", o_exp); end
    if (o_zero !== 1'b0) begin bad++; $display("FAIL norm_zero got %b exp 0", o_zero); end
    if (o_underflow !== 1'b0) begin bad++; $display("FAIL norm_uf got %b exp 0", o_underflow); end
    // Out-of-range count clamps to 40: only bit 0 set.
    send(41'h1, 8'd100, 6'd50);
    tick();
    total += 2;
    if (o_mant !== 41'h100_0000_0000) begin bad++; $display("FAIL clamp_mant got %h exp 10000000000", o_mant); end
    if (o_exp !== 8'd60) begin bad++; $display("FAIL clamp_exp got %0d exp 60", o_exp); end
    drain();
  endtask

  task automatic test_zero();
    i_ready = 1'b1; chk_lat = 1'b1;
    send(41'h0, 8'd50, 6'd40);
    tick();
    total += 4;
    if (o_zero !== 1'b1) begin bad++; $display("FAIL zero_flag got %b exp 1", o_zero); end
    if (o_mant !== 41'h0) begin bad++; $display("FAIL zero_mant got %h exp 0", o_mant); end
    if (o_exp !== 8'd0) begin bad++; $display("FAIL zero_exp got %0d exp 0", o_exp); end
    if (o_underflow !== 1'b0) begin bad++; $display("FAIL zero_uf got %b exp 0", o_underflow); end
    drain();
  endtask

  task automatic test_underflow();
    i_ready = 1'b1; chk_lat = 1'b1;
    send(41'h000_0010_0000, 8'd5, 6'd20);
    tick();
    total += 3;
    if (o_mant !== 41'h000_0200_0000) begin bad++; $display("FAIL uf_mant got %h exp 2000000", o_mant); end
    if (o_exp !== 8'd0) begin bad++; $display("FAIL uf_exp got %0d exp 0", o_exp); end
    if (o_underflow !== 1'b1) begin bad++; $display("FAIL uf_flag got %b exp 1", o_underflow); end
    // lzd == exp is still an underflow.
    send(41'h008_0000_0000, 8'd5, 6'd5);
    tick();
    total += 3;
    if (o_mant !== 41'h100_0000_0000) begin bad++; $display("FAIL ufeq_mant got %h exp 10000000000", o_mant); end
    if (o_exp !== 8'd0) begin bad++; $display("FAIL ufeq_exp got %0d exp 0", o_exp); end
    if (o_underflow !== 1'b1) begin bad++; $display("FAIL ufeq_flag got %b exp 1", o_underflow); end
    // Exponent 0: no shift at all.
    send(41'h1, 8'd0, 6'd40);
    drain();
  endtask

  task automatic test_backpressure();
    beat_t h;
    int p0;
    i_ready = 1'b0; chk_lat = 1'b0;
    h = model(41'h000_0000_1234, 8'd90, 6'd28);
    i_valid = 1'b1;
    i_mant = 41'h000_0000_1234; i_exp = 8'd90; i_lzd_num = 6'd28; tick();
    i_mant = 41'h100_0000_0000; i_exp = 8'd7;  i_lzd_num = 6'd0;  tick();
    i_mant = 41'h000_0400_0000; i_exp = 8'd3;  i_lzd_num = 6'd14;
    for (int k = 0; k < 4; k++) begin
      total += 3;
      if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready c%0d got %b exp 0", k, o_ready); end
      if (o_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c%0d got %b exp 1", k, o_valid); end
      if ({o_mant, o_exp} !== {h.mant, h.exp}) begin
        bad++; $display("FAIL bp_hold c%0d got %h/%0d exp %h/%0d", k, o_mant, o_exp, h.mant, h.exp);
      end
      tick();
    end
    p0 = pops;
    i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    drain();
    total++;
    if (pops - p0 !== 3) begin bad++; $display("FAIL bp_count got %0d exp 3", pops - p0); end
  endtask

  task automatic test_stream();
    logic [40:0] m;
    int p0;
    i_ready = 1'b1; chk_lat = 1'b1;
    p0 = pops;
    for (int k = 0; k < 16; k++) begin
      m = 41'({$urandom, $urandom});
      m = m >> $urandom_range(0, 40);
      if (k == 5) m = '0;
      i_valid = 1'b1; i_mant = m; i_lzd_num = count_lz(m);
      i_exp = 8'($urandom_range(0, 60));
      total++;
      if (o_ready !== 1'b1) begin bad++; $display("FAIL stream_ready k%0d got %b exp 1", k, o_ready); end
      tick();
    end
    i_valid = 1'b0;
    drain();
    total++;
    if (pops - p0 !== 16) begin bad++; $display("FAIL stream_count got %0d exp 16", pops - p0); end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0; chk_lat = 1'b0;
    i_valid = 1'b1;
    i_mant = 41'h0_0001_0000; i_exp = 8'd40; i_lzd_num = count_lz(41'h0_0001_0000); tick();
    i_mant = 41'h0_0000_00ff; i_exp = 8'd80; i_lzd_num = count_lz(41'h0_0000_00ff); tick();
    i_rst = 1'b1;
    tick();
    sb.delete();
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got %b exp 0", o_valid); end
    tick();
    i_rst = 1'b0; i_valid = 1'b0;
    tick();
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got %b exp 1", o_ready); end
    i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (o_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale c%0d got %b exp 0", k, o_valid); end
      tick();
    end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_mant = '0; i_exp = '0; i_lzd_num = '0;
    test_reset();
    test_normal();
    test_zero();
    test_underflow();
    test_backpressure();
    test_stream();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
